// File: rtl/lal_seq.sv
// lal_seq: load / count-down / done sequencer with a registered compare.
// Three-state FSM (IDLE, RUN, DONE) plus an independent a == k flag.
module lal_seq #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    input  logic             clr,
    input  logic [3:0]       a,
    input  logic [3:0]       k,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             match
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             match_q;
    logic             match_d;
    logic             cnt_is_zero;

    assign cnt_is_zero = (cnt_q == CNT_ZERO);

    // Next state and next count; clr beats every other control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        cnt_d   = load_val;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (cnt_is_zero) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Compare flag runs every cycle regardless of the FSM.
    always_comb begin
        match_d = (a == k);
    end

    // State, counter and compare registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign cnt   = cnt_q;
    assign zero  = cnt_is_zero;
    assign match = match_q;

endmodule

// File: tb/tb_lal_seq.sv
// Testbench for lal_seq: directed vectors, literal expectations and a
// cycle-level reference model checked on every falling edge.
module tb_lal_seq;

    localparam int W = 9;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] load_val;
    logic         hold;
    logic         clr;
    logic [3:0]   a;
    logic [3:0]   k;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] cnt;
    logic         zero;
    logic         match;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model: phase 0 = idle, 1 = counting, 2 = finished pulse.
    int           m_phase;
    logic [W-1:0] m_cnt;
    logic         m_match;

    lal_seq #(.CNT_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .load_val(load_val),
        .hold(hold),
        .clr(clr),
        .a(a),
        .k(k),
        .ready(ready),
        .busy(busy),
        .done(done),
        .cnt(cnt),
        .zero(zero),
        .match(match)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model advances on each rising edge from the inputs held stable there.
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= '0;
            m_match <= 1'b0;
        end else begin
            m_match <= (a == k);
            if (clr) begin
                m_phase <= 0;
                m_cnt   <= '0;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_phase <= 1;
                    m_cnt   <= load_val;
                end
            end else if (m_phase == 1) begin
                if (!hold) begin
                    if (m_cnt == 0) m_phase <= 2;
                    else m_cnt <= m_cnt - 1;
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model every cycle once reset has run.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cnt", int'(cnt), int'(m_cnt));
            chk("m_ready", int'(ready), int'(m_phase == 0));
            chk("m_busy", int'(busy), int'(m_phase == 1));
            chk("m_done", int'(done), int'(m_phase == 2));
            chk("m_zero", int'(zero), int'(m_cnt == 0));
            chk("m_match", int'(match), int'(m_match));
            chk("onehot", int'(ready) + int'(busy) + int'(done), 1);
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a run of n, optionally holding, and count edges until done.
    task automatic run(input logic [W-1:0] n, input int hf, input int hl,
                       output int cyc);
        load_val = n;
        start    = 1;
        cyc      = 0;
        while (1) begin
            cyc++;
            hold = (cyc >= hf) && (cyc < hf + hl);
            tick();
            start = 0;
            if (done) break;
            if (cyc > 1000) begin
                chk("run_timeout", cyc, -1);
                break;
            end
        end
        hold = 0;
    endtask

    int cyc;
    int pulses;

    initial begin
        rst = 1; start = 0; load_val = '0; hold = 0; clr = 0;
        a = 4'h1; k = 4'h2;
        @(negedge clk);
        tick();
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_match", int'(match), 0);
        chk_en = 1;
        rst = 0;

        // Basic run of 3.
        load_val = 3; start = 1;
        tick();
        start = 0;
        for (int i = 3; i >= 0; i--) begin
            chk("basic_busy", int'(busy), 1);
            chk("basic_cnt", int'(cnt), i);
            tick();
        end
        chk("basic_done", int'(done), 1);
        tick();
        chk("basic_ready", int'(ready), 1);

        // Latency without and with two hold cycles.
        run(2, 0, 0, cyc);
        chk("lat_nohold", cyc, 4);
        tick();
        run(2, 2, 2, cyc);
        chk("lat_hold2", cyc, 6);
        tick();

        // Abort with clr when cnt is 3.
        load_val = 5; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("abort_pre", int'(cnt), 3);
        clr = 1;
        tick();
        clr = 0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_cnt", int'(cnt), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort_nodone", pulses, 0);

        // load_val = 0: one busy cycle then done.
        load_val = 0; start = 1;
        tick();
        start = 0;
        chk("z_busy", int'(busy), 1);
        chk("z_zero", int'(zero), 1);
        tick();
        chk("z_done", int'(done), 1);
        tick();

        // Full-scale load.
        run(511, 0, 0, cyc);
        chk("lat_511", cyc, 513);
        tick();

        // start held high: new run follows each done via one idle cycle.
        load_val = 1; start = 1;
        tick();
        chk("sh_busy1", int'(busy), 1);
        tick();
        tick();
        chk("sh_done", int'(done), 1);
        tick();
        chk("sh_idle", int'(ready), 1);
        tick();
        chk("sh_busy2", int'(busy), 1);
        chk("sh_cnt2", int'(cnt), 1);
        start = 0; clr = 1;
        tick();
        clr = 0;

        // start with clr stays idle.
        start = 1; clr = 1; load_val = 7;
        tick();
        start = 0; clr = 0;
        chk("sc_ready", int'(ready), 1);
        chk("sc_cnt", int'(cnt), 0);

        // Compare in idle and during a run.
        a = 4'hA; k = 4'hA;
        tick();
        chk("cmp_eq", int'(match), 1);
        k = 4'h5;
        tick();
        chk("cmp_ne", int'(match), 0);
        load_val = 9; start = 1; a = 4'h3; k = 4'h3;
        tick();
        start = 0;
        chk("cmp_run_eq", int'(match), 1);
        k = 4'h4;
        tick();
        chk("cmp_run_ne", int'(match), 0);
        chk("cmp_run_busy", int'(busy), 1);
        clr = 1;
        tick();
        clr = 0;

        // Reset while cnt is 7.
        load_val = 10; start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        chk("mr_pre", int'(cnt), 7);
        a = 4'h6; k = 4'h6; rst = 1; start = 1; clr = 1;
        tick();
        rst = 0; clr = 0; start = 1; load_val = 2;
        chk("mr_cnt", int'(cnt), 0);
        chk("mr_match", int'(match), 0);
        chk("mr_ready", int'(ready), 1);
        tick();
        start = 0;
        chk("mr_start", int'(busy), 1);
        chk("mr_load", int'(cnt), 2);
        tick(); tick(); tick();
        chk("mr_done", int'(done), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lal_seq.md
LAL_SEQ -- requirements
Module: lal_seq

Interface
REQ-001 SHALL provide parameter CNT_W, default 9, counter width in bits.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL provide port start  input  1  run request; accepted only in IDLE.
REQ-005 SHALL provide port load_val  input  CNT_W  initial count, captured on the accepted start.
REQ-006 SHALL provide port hold  input  1  freezes counting while high in RUN.
REQ-007 SHALL provide port clr  input  1  abort; forces IDLE from any state.
REQ-008 SHALL provide port a  input  4  compare operand A.
REQ-009 SHALL provide port k  input  4  compare operand K.
REQ-010 SHALL provide port ready  output  1  high exactly when state is IDLE.
REQ-011 SHALL provide port busy  output  1  high exactly when state is RUN.
REQ-012 SHALL provide port done  output  1  one-cycle pulse, high exactly when state is DONE.
REQ-013 SHALL provide port cnt  output  CNT_W  current counter register.
REQ-014 SHALL provide port zero  output  1  combinational (cnt == 0).
REQ-015 SHALL provide port match  output  1  registered (a == k).

Function
REQ-016 SHALL implement states IDLE, RUN and DONE, with all outputs except zero taken directly from registers or decoded from state.
REQ-017 IDLE: on start=1 and clr=0, SHALL load cnt <= load_val and go to RUN; otherwise SHALL stay in IDLE with cnt unchanged.
REQ-018 RUN, hold=1, clr=0: SHALL leave cnt and state unchanged.
REQ-019 RUN, hold=0, clr=0, cnt != 0: SHALL decrement cnt by 1 and stay in RUN.
REQ-020 RUN, hold=0, clr=0, cnt == 0: SHALL go to DONE with cnt held at 0.
REQ-021 DONE: SHALL return to IDLE unconditionally on the next cycle; start in DONE SHALL be ignored.
REQ-022 start in RUN or DONE SHALL be ignored, with no effect on cnt or state.
REQ-023 clr=1 in any state SHALL go to IDLE with cnt <= 0 and no done pulse.
REQ-024 clr SHALL take priority over start, hold and counting when asserted simultaneously.
REQ-025 Latency: start accepted at edge t with load_val=N and hold low throughout SHALL give busy high from t+1 to t+N+1 and done high on cycle t+N+2 only.
REQ-026 Each hold cycle in RUN SHALL extend the done latency by exactly one cycle.
REQ-027 load_val=0 SHALL give exactly one RUN cycle, then DONE.
REQ-028 cnt SHALL never wrap below 0; an all-ones load_val SHALL count down normally.
REQ-029 match SHALL update every cycle in every state, independent of the FSM: match <= (a == k), one-cycle latency.
REQ-030 ready, busy and done SHALL be mutually exclusive and exactly one SHALL be high every cycle.

Reset
REQ-031 rst=1 SHALL force state IDLE, cnt=0 and match=0 at the next edge, giving ready=1, busy=0, done=0, zero=1.
REQ-032 rst SHALL override clr, start, hold and the compare.
REQ-033 rst asserted mid-RUN SHALL abort the run with no done pulse.
REQ-034 After rst deasserts, a start SHALL be accepted on the first edge.

Verification
REQ-035 Basic run: reset, then start=1 for one cycle with load_val=3 and hold=0 -> cnt 3,2,1,0 over four cycles with busy=1, then done=1 for one cycle, then ready=1.
REQ-036 Hold: load_val=2, hold=1 for two cycles in the middle of the run -> done arrives 2 cycles later than without hold, and cnt is frozen during hold.
REQ-037 Abort: load_val=5, clr=1 when cnt=3 -> next cycle ready=1, cnt=0, no done pulse in the following 10 cycles.
REQ-038 Corner cases: load_val=0 -> one busy cycle, then done; load_val=511 -> done exactly 513 cycles after the start edge; start held high continuously -> a new run starts on the cycle after each done; start together with clr -> remains IDLE.
REQ-039 Compare: a=4'hA, k=4'hA -> match=1 one cycle later; then k=4'h5 -> match=0 one cycle later; behaviour is identical while RUN is active.
REQ-040 Reset mid-run: rst=1 while cnt=7 -> next cycle cnt=0, match=0, ready=1; start on the first edge after reset deasserts is accepted.
